branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//  EX-stage branch resolution; the producer of predictor training traffic. Evaluates
//  branch/jump conditions and targets, and compares them with the IFU prediction carried
//  down the pipe. Issues a registered update to the branch predictor, plus a
//  redirect/flush on mispredict. Also keeps branch and mispredict performance counters.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles in FLUSH state; ex_valid is treated as wrong-path and ignored
//  CNT_W         32  width of performance counters
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, asynchronous, active-high
//  ex_stall        in   1   EX held; inputs are not sampled this cycle
//  ex_valid        in   1   EX holds a live instruction
//  ex_pc           in   32  PC of EX instruction
//  ex_is_jmp       in   1   instruction is a branch or jump
//  ex_br_type      in   3   0 BEQ,1 BNE,2 BGEZ,3 BGTZ,4 BLEZ,5 BLTZ,6 J/JAL,7 JR/JALR
//  ex_rs_val       in   32  rs operand (signed for compares)
//  ex_rt_val       in   32  rt operand
//  ex_imm_target   in   32  precomputed PC-relative / J-format target
//  ex_pred_taken   in   1   prediction made in IFU
//  ex_pred_target  in   32  predicted target
//  upd_valid       out  1   predictor update strobe (drives predictor ex_is_jmp)
//  upd_pc          out  32  resolved branch PC
//  upd_act_taken   out  1   actual direction
//  upd_act_target  out  32  actual target
//  upd_stall       out  1   high when no update this cycle (drives predictor ex_stall)
//  redirect_valid  out  1   one-cycle pulse: IFU must fetch from redirect_pc
//  redirect_pc     out  32  corrected fetch PC
//  flush_front     out  1   kill IF/ID while in FLUSH state
//  branch_cnt      out  CNT_W  resolved branches (wraps)
//  mispred_cnt     out  CNT_W  mispredicts (wraps)
// BEHAVIOUR
//  - Reset: all outputs 0; upd_stall=1; FSM=IDLE; counters 0. Reset mid-FLUSH aborts to IDLE.
//  - Sample condition: accept = ~ex_stall & ex_valid & ex_is_jmp & (state==IDLE).
//  - act_taken: BEQ rs==rt; BNE rs!=rt; BGEZ rs>=0; BGTZ rs>0; BLEZ rs<=0; BLTZ rs<0 (signed);
//    types 6 and 7 are always taken.
//  - act_target = (type==7) ? ex_rs_val : ex_imm_target. Fallthrough = ex_pc+8 (delay slot),
//    mod 2^32.
//  - mispred = (act_taken != ex_pred_taken) | (act_taken & ex_pred_taken & act_target != ex_pred_target).
//  - Latency 1: all upd_*/redirect_* outputs are registered and appear the cycle after accept.
//  - upd_valid=1 and upd_stall=0 for exactly one cycle per accept; otherwise upd_valid=0,
//    upd_stall=1, and the upd_* data holds its last value.
//  - redirect_pc = act_taken ? act_target : ex_pc+8. redirect_valid pulses only on mispred.
//  - FSM IDLE->FLUSH on accept&mispred (taken the same edge the outputs register).
//    FLUSH: flush_front=1; a down-counter is loaded with FLUSH_CYCLES-1.
//    FLUSH->IDLE when the counter reaches 0. Total flush_front high = FLUSH_CYCLES cycles.
//  - In FLUSH: ex_valid inputs are ignored. No update and no counter change occur.
//    ex_stall does not freeze the counter.
//  - Counters: branch_cnt+1 on each accept; mispred_cnt+1 on accept&mispred.
//    Both wrap at 2^CNT_W.
//  - ex_stall & ex_valid: no sample; the instruction is re-presented later and counted once.
//  - Correct predictions: update only, with no redirect and no flush.
// TESTING
//  1 Reset: assert rst async mid-cycle -> all outputs 0, upd_stall=1 immediately, counters 0.
//  2 BEQ pc=0x100, rs=rt=5, pred_taken=1, pred_target=0x200=imm -> next cycle upd_valid=1,
//    upd_act_taken=1, no redirect; branch_cnt=1, mispred_cnt=0.
//  3 BNE pc=0x100, rs=rt, pred_taken=1 -> redirect_valid pulse with redirect_pc=0x108;
//    flush_front high 2 cycles; mispred_cnt=1; an ex_valid branch during flush is ignored
//    (branch_cnt unchanged).
//  4 JR pc=0x40, rs=0x8000, pred_taken=1, pred_target=0x7FFC -> target mispredict,
//    redirect_pc=0x8000, upd_act_target=0x8000.
//  5 BLTZ rs=0x80000000 with ex_stall=1 for 3 cycles, then 0 -> exactly one update
//    (act_taken=1) after the stall releases; branch_cnt+1 once.
//  6 pc=0xFFFFFFFC, BGTZ rs=0, pred_taken=1 -> redirect_pc=0x00000004 (wrap); rst asserted
//    during FLUSH -> flush_front drops at once, FSM IDLE.

Source files
------------

// File: rtl/branch_resolver_if.sv
// ---------------------------------------------------------------------------
// branch_resolver_if
//   Bundles the EX-stage branch operands coming down the pipe with the
//   results that the branch resolver sends back: the predictor training
//   update, the fetch redirect, the front-end flush and the performance
//   counters.
//   master : pipeline side. It drives the ex_* signals and observes the results.
//   slave  : the branch_resolver itself.
//   Signals:
//     ex_stall, ex_valid, ex_pc[31:0], ex_is_jmp, ex_br_type[2:0],
//     ex_rs_val[31:0], ex_rt_val[31:0], ex_imm_target[31:0],
//     ex_pred_taken, ex_pred_target[31:0]                     (to resolver)
//     upd_valid, upd_pc[31:0], upd_act_taken, upd_act_target[31:0],
//     upd_stall, redirect_valid, redirect_pc[31:0], flush_front,
//     branch_cnt[CNT_W-1:0], mispred_cnt[CNT_W-1:0]           (from resolver)
// ---------------------------------------------------------------------------
interface branch_resolver_if #(
  parameter int CNT_W = 32
);
  logic             ex_stall;
  logic             ex_valid;
  logic [31:0]      ex_pc;
  logic             ex_is_jmp;
  logic [2:0]       ex_br_type;
  logic [31:0]      ex_rs_val;
  logic [31:0]      ex_rt_val;
  logic [31:0]      ex_imm_target;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;

  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_act_taken;
  logic [31:0]      upd_act_target;
  logic             upd_stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_front;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output ex_stall, ex_valid, ex_pc, ex_is_jmp, ex_br_type, ex_rs_val,
           ex_rt_val, ex_imm_target, ex_pred_taken, ex_pred_target,
    input  upd_valid, upd_pc, upd_act_taken, upd_act_target, upd_stall,
           redirect_valid, redirect_pc, flush_front, branch_cnt, mispred_cnt
  );

  modport slave (
    input  ex_stall, ex_valid, ex_pc, ex_is_jmp, ex_br_type, ex_rs_val,
           ex_rt_val, ex_imm_target, ex_pred_taken, ex_pred_target,
    output upd_valid, upd_pc, upd_act_taken, upd_act_target, upd_stall,
           redirect_valid, redirect_pc, flush_front, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//   EX-stage branch resolution. It evaluates the branch condition and target,
//   then compares them with the prediction made at fetch. For every accepted
//   branch it issues a registered predictor update one cycle later. On a
//   mispredict it also pulses a fetch redirect and holds flush_front for
//   FLUSH_CYCLES cycles. While that flush runs, the instructions arriving in
//   EX are on the wrong path and are ignored.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-high reset
//     br   : branch_resolver_if.slave (EX operands in; update, redirect,
//            flush and performance counters out)
// ---------------------------------------------------------------------------
module branch_resolver #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolver_if.slave br
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q;
  logic [FC_W-1:0]  flush_cnt_q;

  logic             upd_valid_q;
  logic [31:0]      upd_pc_q;
  logic             upd_act_taken_q;
  logic [31:0]      upd_act_target_q;
  logic             upd_stall_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic             flush_front_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  // Combinational resolution of the instruction currently in EX.
  logic        accept_d;
  logic        act_taken_d;
  logic [31:0] act_target_d;
  logic [31:0] fallthru_d;
  logic        mispred_d;
  logic        rs_neg_d;
  logic        rs_zero_d;

  assign rs_neg_d  = br.ex_rs_val[31];
  assign rs_zero_d = (br.ex_rs_val == 32'd0);

  always_comb begin
    act_taken_d = 1'b0;
    case (br.ex_br_type)
      3'd0:    act_taken_d = (br.ex_rs_val == br.ex_rt_val);
      3'd1:    act_taken_d = (br.ex_rs_val != br.ex_rt_val);
      3'd2:    act_taken_d = ~rs_neg_d;
      3'd3:    act_taken_d = ~rs_neg_d & ~rs_zero_d;
      3'd4:    act_taken_d = rs_neg_d | rs_zero_d;
      3'd5:    act_taken_d = rs_neg_d;
      default: act_taken_d = 1'b1;  // J/JAL and JR/JALR
    endcase
  end

  assign act_target_d = (br.ex_br_type == 3'd7) ? br.ex_rs_val : br.ex_imm_target;
  // The fallthrough skips the delay slot. It wraps modulo 2^32.
  assign fallthru_d   = br.ex_pc + 32'd8;
  // A correct direction with the wrong target only counts when both sides say taken.
  assign mispred_d    = (act_taken_d != br.ex_pred_taken) |
                        (act_taken_d & br.ex_pred_taken &
                         (act_target_d != br.ex_pred_target));
  assign accept_d     = ~br.ex_stall & br.ex_valid & br.ex_is_jmp & (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      flush_cnt_q      <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_act_taken_q  <= 1'b0;
      upd_act_target_q <= '0;
      upd_stall_q      <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_front_q    <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      // Strobes default low. The update data and redirect_pc hold their last values.
      upd_valid_q      <= 1'b0;
      upd_stall_q      <= 1'b1;
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            upd_valid_q      <= 1'b1;
            upd_stall_q      <= 1'b0;
            upd_pc_q         <= br.ex_pc;
            upd_act_taken_q  <= act_taken_d;
            upd_act_target_q <= act_target_d;
            branch_cnt_q     <= branch_cnt_q + 1'b1;
            if (mispred_d) begin
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= act_taken_d ? act_target_d : fallthru_d;
              mispred_cnt_q    <= mispred_cnt_q + 1'b1;
              state_q          <= FLUSH;
              flush_front_q    <= 1'b1;
              flush_cnt_q      <= FC_LOAD;
            end
          end
        end
        FLUSH: begin
          // The count runs regardless of ex_stall. flush_front stays high while
          // the count falls from FC_LOAD to zero, then drops with the return to IDLE.
          if (flush_cnt_q == '0) begin
            state_q       <= IDLE;
            flush_front_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          flush_front_q <= 1'b0;
        end
      endcase
    end
  end

  assign br.upd_valid      = upd_valid_q;
  assign br.upd_pc         = upd_pc_q;
  assign br.upd_act_taken  = upd_act_taken_q;
  assign br.upd_act_target = upd_act_target_q;
  assign br.upd_stall      = upd_stall_q;
  assign br.redirect_valid = redirect_valid_q;
  assign br.redirect_pc    = redirect_pc_q;
  assign br.flush_front    = flush_front_q;
  assign br.branch_cnt     = branch_cnt_q;
  assign br.mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
//   Directed scenarios plus a randomized run. A transaction-level model
//   predicts every registered output, cycle by cycle.
// ---------------------------------------------------------------------------
module tb_branch_resolver;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  branch_resolver_if #(.CNT_W(CNT_W)) bus ();

  branch_resolver #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .br  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [31:0] m_branch, m_mispred, m_upd_pc, m_upd_target, m_redir_pc;
  logic        m_upd_taken, m_upd_valid, m_redir_valid;
  int          m_flush_rem;  // number of upcoming post-edge cycles with flush_front high

  function automatic logic ref_taken(input logic [2:0] t, input logic [31:0] rs,
                                     input logic [31:0] rt);
    case (t)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return $signed(rs) >= 0;
      3'd3:    return $signed(rs) > 0;
      3'd4:    return $signed(rs) <= 0;
      3'd5:    return $signed(rs) < 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_branch = 0; m_mispred = 0; m_upd_pc = 0; m_upd_target = 0; m_redir_pc = 0;
    m_upd_taken = 0; m_upd_valid = 0; m_redir_valid = 0; m_flush_rem = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    check({step, ".upd_valid"},      64'(bus.upd_valid),      64'(m_upd_valid));
    check({step, ".upd_stall"},      64'(bus.upd_stall),      64'(!m_upd_valid));
    check({step, ".upd_pc"},         64'(bus.upd_pc),         64'(m_upd_pc));
    check({step, ".upd_act_taken"},  64'(bus.upd_act_taken),  64'(m_upd_taken));
    check({step, ".upd_act_target"}, 64'(bus.upd_act_target), 64'(m_upd_target));
    check({step, ".redirect_valid"}, 64'(bus.redirect_valid), 64'(m_redir_valid));
    check({step, ".redirect_pc"},    64'(bus.redirect_pc),    64'(m_redir_pc));
    check({step, ".flush_front"},    64'(bus.flush_front),    64'(m_flush_rem > 0));
    check({step, ".branch_cnt"},     64'(bus.branch_cnt),     64'(m_branch));
    check({step, ".mispred_cnt"},    64'(bus.mispred_cnt),    64'(m_mispred));
  endtask

  // Predict what the next clock edge produces from the current inputs,
  // advance one clock, then compare.
  task automatic cycle(input string step);
    logic idle, acc, tk, mp;
    logic [31:0] tg;
    idle = (m_flush_rem == 0);
    if (!idle) m_flush_rem--;
    acc = idle && !bus.ex_stall && bus.ex_valid && bus.ex_is_jmp;
    tk  = ref_taken(bus.ex_br_type, bus.ex_rs_val, bus.ex_rt_val);
    tg  = (bus.ex_br_type == 3'd7) ? bus.ex_rs_val : bus.ex_imm_target;
    mp  = (tk != bus.ex_pred_taken) || (tk && bus.ex_pred_taken && tg != bus.ex_pred_target);
    m_upd_valid   = acc;
    m_redir_valid = acc && mp;
    if (acc) begin
      m_upd_pc     = bus.ex_pc;
      m_upd_taken  = tk;
      m_upd_target = tg;
      m_branch     = m_branch + 1;
      if (mp) begin
        m_redir_pc  = tk ? tg : bus.ex_pc + 32'd8;
        m_mispred   = m_mispred + 1;
        m_flush_rem = FLUSH_CYCLES;
      end
    end
    @(posedge clk);
    #1;
    $display("[TB] %s: stall=%0b valid=%0b jmp=%0b type=%0d pc=%h -> upd=%0b redir=%0b rpc=%h flush=%0b br=%0d mp=%0d",
             step, bus.ex_stall, bus.ex_valid, bus.ex_is_jmp, bus.ex_br_type, bus.ex_pc,
             bus.upd_valid, bus.redirect_valid, bus.redirect_pc, bus.flush_front,
             bus.branch_cnt, bus.mispred_cnt);
    check_all(step);
  endtask

  task automatic drive(input logic stall, input logic valid, input logic jmp,
                       input logic [2:0] t, input logic [31:0] pc, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] imm, input logic pt,
                       input logic [31:0] ptg);
    bus.ex_stall = stall; bus.ex_valid = valid; bus.ex_is_jmp = jmp; bus.ex_br_type = t;
    bus.ex_pc = pc; bus.ex_rs_val = rs; bus.ex_rt_val = rt; bus.ex_imm_target = imm;
    bus.ex_pred_taken = pt; bus.ex_pred_target = ptg;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] rs, rt, imm, ptg;
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    idle_in();
    model_reset();

    // 1: asynchronous reset asserted between edges
    #2 rst = 1'b1;
    #1 $display("[TB] reset asserted mid-cycle");
    check_all("reset");
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    // 2: BEQ predicted correctly
    drive(1'b0, 1'b1, 1'b1, 3'd0, 32'h100, 32'd5, 32'd5, 32'h200, 1'b1, 32'h200);
    cycle("beq_ok");
    idle_in();
    cycle("beq_ok_after");

    // 3: BNE not taken but predicted taken; a branch offered during the flush is dropped
    drive(1'b0, 1'b1, 1'b1, 3'd1, 32'h100, 32'd7, 32'd7, 32'h200, 1'b1, 32'h200);
    cycle("bne_mp");
    drive(1'b0, 1'b1, 1'b1, 3'd0, 32'h104, 32'd1, 32'd1, 32'h300, 1'b0, 32'h0);
    cycle("flush1");
    cycle("flush2");
    idle_in();
    cycle("flush_end");

    // 4: JR target mispredict
    drive(1'b0, 1'b1, 1'b1, 3'd7, 32'h40, 32'h8000, 32'd0, 32'h1234, 1'b1, 32'h7FFC);
    cycle("jr_mp");
    idle_in();
    repeat (3) cycle("jr_flush");

    // 5: BLTZ held for three cycles by ex_stall, then accepted exactly once
    drive(1'b1, 1'b1, 1'b1, 3'd5, 32'h500, 32'h80000000, 32'd0, 32'h600, 1'b1, 32'h600);
    repeat (3) cycle("bltz_stall");
    bus.ex_stall = 1'b0;
    cycle("bltz_go");
    idle_in();
    cycle("bltz_after");

    // 6: the fallthrough wraps past 2^32; reset lands in the middle of the flush
    drive(1'b0, 1'b1, 1'b1, 3'd3, 32'hFFFFFFFC, 32'd0, 32'd0, 32'h900, 1'b1, 32'h900);
    cycle("bgtz_wrap");
    idle_in();
    #3 rst = 1'b1;
    #1 model_reset();
    $display("[TB] reset asserted during flush");
    check_all("reset_in_flush");
    #1 rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 3'd6, 32'h20, 32'd0, 32'd0, 32'h80, 1'b1, 32'h80);
    cycle("j_after_reset");
    idle_in();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: rs = 32'd0;
        1: rs = 32'd1;
        2: rs = 32'hFFFFFFFF;
        3: rs = 32'h80000000;
        default: rs = $urandom;
      endcase
      rt  = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      imm = $urandom & 32'hFFFFFFFC;
      ptg = ($urandom_range(0, 2) != 0) ? (($urandom_range(0, 1) == 1) ? imm : rs) : $urandom;
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
            3'($urandom_range(0, 7)), $urandom & 32'hFFFFFFFC, rs, rt, imm,
            1'($urandom_range(0, 1)), ptg);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
